streamcalc_ctrl: RTL
====================

Name: streamcalc_ctrl

Overview:
Token-driven sequencer that acts as the initiator side of the streamcalc queue interface. It accepts a stream of calculator tokens (number, operator, pop, emit) over a valid/ready handshake and computes operator results from the queue's first and second entries. It issues the matching apply/op/in commands to the queue and returns emitted values on a result handshake. It mirrors the queue occupancy internally so that it never issues an illegal command.

Parameters:
W, 8, data width of tokens, queue entries and results
DEPTH, 11, queue capacity in entries; must match the attached queue

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
tok_valid  input  1  token present
tok_ready  output  1  controller can accept token
tok_op  input  3  0 add, 1 sub, 2 mul, 3 and, 4 xor, 5 push, 6 pop, 7 emit
tok_data  input  W  operand for push; ignored otherwise
q_apply  output  1  one-cycle command strobe to queue
q_op  output  3  queue op code
q_in  output  W  value to queue: push operand or operator result
q_first  input  W  queue head entry
q_second  input  W  queue entry behind head
q_empty  input  1  queue empty flag
q_valid  input  1  queue sticky valid flag
res_valid  output  1  emitted result present
res_ready  input  1  consumer accepts result
res_data  output  W  emitted value
err  output  1  sticky error
err_code  output  2  1 underflow, 2 overflow, 3 queue reported invalid
count  output  4  mirrored queue occupancy, 0..DEPTH

Behaviour:
- Reset is async active-high, per the already-decided interface. Reset values: state IDLE, count=0, q_apply=0, q_op=0, q_in=0, res_valid=0, res_data=0, err=0, err_code=0. tok_ready=0 while rst is asserted.
- FSM states: IDLE, EXEC, EMIT, ERR.
- IDLE: tok_ready=1. A token is accepted when tok_valid&&tok_ready; tok_op and tok_data are registered at that point. Legality is checked against count in the accept cycle:
  - ops 0-4 require count>=2.
  - ops 6 and 7 require count>=1.
  - op 5 requires count<DEPTH.
  - An illegal token moves the FSM to ERR with err_code 1 (underflow) or 2 (overflow). No q_apply is issued.
- Legal ops 0-6: go to EXEC. Legal op 7: go to EMIT, with res_data <= q_first and res_valid <= 1.
- EXEC (exactly one cycle, tok_ready=0):
  - q_apply=1 and q_op=registered op.
  - Ops 0-4: q_in = ALU(q_first, q_second), where the left operand is q_first. Results are truncated to W bits (mul keeps the low W bits; sub wraps modulo 2^W).
  - Op 5: q_in = registered data.
  - Op 6: q_in=0.
  - count updates at the end of EXEC: +1 for push, -1 for ops 0-4 and op 6.
  - Next state is IDLE.
- Latency: token accepted in cycle N; q_apply is high in cycle N+1. The next token can be accepted in cycle N+2.
- q_first and q_second are stable in EXEC, because the queue changes only on q_apply.
- q_apply is 0 in every state except EXEC.
- EMIT: res_valid stays high and res_data is held until res_ready is high. The transfer completes in that cycle; res_valid drops and the FSM returns to IDLE. tok_ready=0 throughout EMIT. The queue is unchanged.
- ERR: sticky until rst. tok_ready=0, q_apply=0, and res_valid drops immediately.
- Queue fault: q_valid sampled low in any non-ERR state forces ERR with err_code 3. This takes priority over a simultaneous token accept.
- Consistency check: if q_empty disagrees with (count==0) while in IDLE, the controller raises err_code 3.
- Reset asserted mid-EXEC or mid-EMIT aborts immediately. No partial strobe is issued after reset release.

Optional Feature:
STREAMCALC_SAT_EN
- Defined: add and mul saturate to 2^W-1; sub saturates to 0 when q_first < q_second.
- Undefined: all arithmetic wraps modulo 2^W. Logic ops are unaffected either way.

Test Plan:
- Push 5, push 7, add, emit with res_ready=1 -> q_apply sequence (op,in) = (5,5), (5,7), (0,12); res_data=12; count ends at 1.
- Push 3, push 5, sub -> q_in=8'hFE (3-5 wrapped) without the macro; q_in=0 with STREAMCALC_SAT_EN.
- Add token straight after reset -> no q_apply; err=1, err_code=1; tok_ready stays 0 until rst.
- Eleven pushes, then a twelfth push -> first eleven applied with count=11; twelfth gives err_code=2 and no q_apply.
- Emit with res_ready held low 3 cycles, then high -> res_valid=1 and res_data stable for 4 cycles; tok_ready=0 throughout; one transfer, then IDLE.
- Force q_valid=0 while IDLE with tok_valid high -> token not accepted; err_code=3.

Source files
------------

// File: rtl/streamcalc_ctrl.sv
// streamcalc_ctrl: token-driven initiator for the streamcalc queue.
// Accepts calculator tokens, issues apply/op/in commands to the queue,
// and returns emitted values on a result handshake. It mirrors queue
// occupancy so that it never issues an illegal command.
// Optional feature macro: STREAMCALC_SAT_EN (saturating add/sub/mul).
module streamcalc_ctrl #(
  parameter int W     = 8,
  parameter int DEPTH = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [2:0]   tok_op,
  input  logic [W-1:0] tok_data,
  output logic         q_apply,
  output logic [2:0]   q_op,
  output logic [W-1:0] q_in,
  input  logic [W-1:0] q_first,
  input  logic [W-1:0] q_second,
  input  logic         q_empty,
  input  logic         q_valid,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [3:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    EMIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_PUSH = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_EMIT = 3'd7;

  localparam logic [1:0] EC_UNDER = 2'd1;
  localparam logic [1:0] EC_OVER  = 2'd2;
  localparam logic [1:0] EC_QBAD  = 2'd3;

  state_t         state, state_next;
  logic [3:0]     count_next;
  logic           q_apply_next;
  logic [2:0]     q_op_next;
  logic [W-1:0]   q_in_next;
  logic           res_valid_next;
  logic [W-1:0]   res_data_next;
  logic           err_next;
  logic [1:0]     err_code_next;
  logic           incons;
  logic           accept;
  logic           underflow;
  logic           overflow;

  // Operator result: left operand is the queue head (a), right is the entry behind it (b).
  function automatic logic [W-1:0] alu(input logic [2:0] op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    s = {1'b0, a} + {1'b0, b};
    p = a * b;
    case (op)
`ifdef STREAMCALC_SAT_EN
      OP_ADD:  r = s[W] ? {W{1'b1}} : s[W-1:0];
      OP_SUB:  r = (a < b) ? {W{1'b0}} : (a - b);
      OP_MUL:  r = (|p[2*W-1:W]) ? {W{1'b1}} : p[W-1:0];
`else
      OP_ADD:  r = s[W-1:0];
      OP_SUB:  r = a - b;
      OP_MUL:  r = p[W-1:0];
`endif
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = {W{1'b0}};
    endcase
    return r;
  endfunction

  // Queue fault detection and token legality against the mirrored occupancy.
  always_comb begin
    incons    = (state == IDLE) && (q_empty != (count == 4'd0));
    tok_ready = (state == IDLE) && !rst && q_valid && !incons;
    accept    = tok_valid && tok_ready;
    underflow = ((tok_op <= OP_XOR) && (count < 4'd2)) ||
                (((tok_op == OP_POP) || (tok_op == OP_EMIT)) && (count < 4'd1));
    overflow  = (tok_op == OP_PUSH) && (count >= DEPTH_C);
  end

  // Next-state and next-output logic for the controller FSM.
  always_comb begin
    state_next     = state;
    count_next     = count;
    q_apply_next   = 1'b0;
    q_op_next      = q_op;
    q_in_next      = q_in;
    res_valid_next = res_valid;
    res_data_next  = res_data;
    err_next       = err;
    err_code_next  = err_code;
    case (state)
      IDLE: begin
        if (!q_valid || incons) begin
          state_next    = ERR;
          err_next      = 1'b1;
          err_code_next = EC_QBAD;
        end else if (accept) begin
          if (underflow) begin
            state_next    = ERR;
            err_next      = 1'b1;
            err_code_next = EC_UNDER;
          end else if (overflow) begin
            state_next    = ERR;
            err_next      = 1'b1;
            err_code_next = EC_OVER;
          end else if (tok_op == OP_EMIT) begin
            state_next     = EMIT;
            res_valid_next = 1'b1;
            res_data_next  = q_first;
          end else begin
            state_next   = EXEC;
            q_apply_next = 1'b1;
            q_op_next    = tok_op;
            if (tok_op == OP_PUSH) begin
              q_in_next = tok_data;
            end else if (tok_op == OP_POP) begin
              q_in_next = {W{1'b0}};
            end else begin
              q_in_next = alu(tok_op, q_first, q_second);
            end
          end
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        if (!q_valid) begin
          state_next    = ERR;
          err_next      = 1'b1;
          err_code_next = EC_QBAD;
        end else begin
          state_next = IDLE;
          if (q_op == OP_PUSH) begin
            count_next = count + 4'd1;
          end else if (q_op != OP_EMIT) begin
            count_next = count - 4'd1;
          end else begin
            count_next = count;
          end
        end
      end
      EMIT: begin
        if (!q_valid) begin
          state_next     = ERR;
          err_next       = 1'b1;
          err_code_next  = EC_QBAD;
          res_valid_next = 1'b0;
        end else if (res_ready) begin
          state_next     = IDLE;
          res_valid_next = 1'b0;
        end else begin
          state_next = EMIT;
        end
      end
      ERR: begin
        state_next     = ERR;
        res_valid_next = 1'b0;
      end
      default: begin
        state_next     = ERR;
        err_next       = 1'b1;
        err_code_next  = EC_QBAD;
        res_valid_next = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      q_apply   <= 1'b0;
      q_op      <= 3'd0;
      q_in      <= {W{1'b0}};
      res_valid <= 1'b0;
      res_data  <= {W{1'b0}};
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      q_apply   <= q_apply_next;
      q_op      <= q_op_next;
      q_in      <= q_in_next;
      res_valid <= res_valid_next;
      res_data  <= res_data_next;
      err       <= err_next;
      err_code  <= err_code_next;
    end
  end

endmodule
